texas_top: RTL and testbench
============================

TEXAS_TOP -- requirements
Module: texas_top

Interface
REQ-001 SHALL have parameter DEPTH, default 8, number of entries in the input and output memories; address width ADDR_W = log2(DEPTH).
REQ-002 SHALL have parameter WEIGHTS, default 32'h01020304, four unsigned byte coefficients; c3 = [31:24] … c0 = [7:0].
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_b  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port input_sram_in  input  32  data word written into the input memory.
REQ-006 SHALL have port write_input  input  1  write enable for the input memory.
REQ-007 SHALL have port start  input  1  pulse that launches computation.
REQ-008 SHALL have port read_output  input  1  read-advance for the output memory.
REQ-009 SHALL have port ram_out  output  64  currently addressed output-memory entry, registered.

Function
REQ-010 SHALL write input_sram_in to in_mem[wr_ptr] on each edge with write_input=1, then increment wr_ptr modulo DEPTH (wraps 7->0, overwriting).
REQ-011 SHALL treat each input word as unsigned bytes b3=[31:24], b2, b1, b0=[7:0].
REQ-012 SHALL compute per entry i: dot = b3*c3 + b2*c2 + b1*c1 + b0*c0, unsigned, 18-bit result with no overflow.
REQ-013 SHALL store out_mem[i] = {in_mem[i], 14'b0, dot}, i.e. [63:32] echoes the input word, [31:0] is the zero-extended dot.
REQ-014 SHALL implement FSM IDLE -> COMPUTE -> DONE.
REQ-015 SHALL move IDLE->COMPUTE on an edge with start=1; COMPUTE processes one entry per cycle, i = 0..DEPTH-1, in order.
REQ-016 SHALL move COMPUTE->DONE after entry DEPTH-1 is written (DEPTH cycles after start sampled); DONE->COMPUTE on a new start, restarting at i=0.
REQ-017 SHALL ignore start while in COMPUTE.
REQ-018 SHALL give write_input priority: an input write during COMPUTE still updates in_mem; entries not yet processed use the new value.
REQ-019 SHALL maintain rd_ptr; on each edge with read_output=1, ram_out <= out_mem[rd_ptr] and rd_ptr increments modulo DEPTH; with read_output=0, ram_out holds.
REQ-020 SHALL leave write and read pointers unaffected by start; only reset clears them.
REQ-021 SHALL make read_output during COMPUTE return the current content of out_mem (old or new, per entry).

Reset
REQ-022 SHALL, on an edge with rst_b=1: ram_out=0, wr_ptr=0, rd_ptr=0, compute index=0, state=IDLE, all out_mem entries=0; in_mem contents need not be cleared.
REQ-023 SHALL abort a computation when reset occurs during COMPUTE; reset overrides all other inputs in that cycle.

Structure
REQ-024 SHALL place DEPTH, WEIGHTS default, data widths (32/64), and the FSM state enum in a shared package texas_pkg.
REQ-025 SHALL implement the 4-lane multiply-accumulate as one combinational sub-module dot4 (32-bit data, 32-bit weights in, 18-bit sum out).
REQ-026 SHALL implement memories as register arrays, with no vendor primitives.

Verification
REQ-027 SHALL check reset: assert rst_b for 1 cycle -> ram_out=0, state IDLE.
REQ-028 SHALL check write and compute: write 00000000, 01000000, 01020000, 01020300, 01020304, 00020304, 00000304, 00000004, pulse start, wait 8 cycles, then assert read_output for 8 cycles -> ram_out[31:0] = 0, 1, 5, 14, 30, 29, 25, 16, and ram_out[63:32] echoes each input word.
REQ-029 SHALL check wrap: write 9 words, last = FFFFFFFF -> entry 0 becomes FFFFFFFF; its dot = 255*10 = 2550 (0x9F6).
REQ-030 SHALL check maximum: WEIGHTS = FFFFFFFF, input FFFFFFFF -> dot = 4*65025 = 260100 (0x3F804), no truncation.
REQ-031 SHALL check restart and ignore: start held high through COMPUTE -> exactly one pass of 8 cycles; a second start from DONE recomputes identically.
REQ-032 SHALL check reset during COMPUTE: reset at cycle 3 -> state IDLE, ram_out=0, out_mem all zero, reads return 0.

Source files
------------

// File: rtl/texas_pkg.sv
// texas_pkg: shared constants for the texas_top dot-product block.
//   DEPTH_DEF   - default number of entries in the input/output memories
//   WEIGHTS_DEF - default packed byte coefficients {c3, c2, c1, c0}
//   DATA_W      - input word width, OUT_W - output word width
//   DOT_W       - width of the 4-lane unsigned dot product (never overflows)
//   ST_*        - FSM state encodings
package texas_pkg;

   localparam int          DEPTH_DEF   = 8;
   localparam logic [31:0] WEIGHTS_DEF = 32'h01020304;

   localparam int DATA_W = 32;
   localparam int OUT_W  = 64;
   localparam int DOT_W  = 18;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE    = 2'd0;
   localparam state_t ST_COMPUTE = 2'd1;
   localparam state_t ST_DONE    = 2'd2;

endpackage

// File: rtl/texas_dot4.sv
// dot4: combinational 4-lane unsigned byte multiply-accumulate.
//   data    - four unsigned bytes b3..b0 (b0 = [7:0])
//   weights - four unsigned byte coefficients c3..c0 (c0 = [7:0])
//   dot     - b3*c3 + b2*c2 + b1*c1 + b0*c0, 18 bits (max 4*255*255 fits)
module dot4
   import texas_pkg::*;
(
   input  logic [DATA_W-1:0] data,
   input  logic [DATA_W-1:0] weights,
   output logic [DOT_W-1:0]  dot
);

   always_comb begin
      dot = '0;
      for (int k = 0; k < 4; k++) begin
         dot = dot + DOT_W'(data[8*k +: 8]) * DOT_W'(weights[8*k +: 8]);
      end
   end

endmodule

// File: rtl/texas_top.sv
// texas_top: input memory, one-entry-per-cycle dot-product pass, output memory.
//   clk           - rising-edge clock
//   rst_b         - synchronous active-high reset (clears pointers, FSM, out_mem, ram_out)
//   input_sram_in - word written to in_mem[wr_ptr] when write_input is high
//   write_input   - input memory write enable; wr_ptr wraps modulo DEPTH
//   start         - launches a pass over entries 0..DEPTH-1 (ignored while computing)
//   read_output   - loads ram_out from out_mem[rd_ptr] and advances rd_ptr
//   ram_out       - registered output entry {input word, 14'b0, dot}
module texas_top
   import texas_pkg::*;
#(
   parameter int          DEPTH   = DEPTH_DEF,
   parameter logic [31:0] WEIGHTS = WEIGHTS_DEF
)
(
   input  logic              clk,
   input  logic              rst_b,
   input  logic [DATA_W-1:0] input_sram_in,
   input  logic              write_input,
   input  logic              start,
   input  logic              read_output,
   output logic [OUT_W-1:0]  ram_out
);

   localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int PAD_W  = OUT_W - DATA_W - DOT_W;

   logic [DATA_W-1:0] in_mem  [DEPTH];
   logic [OUT_W-1:0]  out_mem [DEPTH];

   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W-1:0] idx;
   state_t            state;

   logic [DATA_W-1:0] cur_word;
   logic [DOT_W-1:0]  cur_dot;

   // Modulo-DEPTH increment that also works for non-power-of-two depths.
   function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] p);
      return (p == ADDR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // A write landing on the entry being processed this cycle is forwarded,
   // so the pass never uses a value that is already stale.
   always_comb begin
      cur_word = in_mem[idx];
      if (write_input && (wr_ptr == idx)) begin
         cur_word = input_sram_in;
      end
   end

   dot4 u_dot4 (
      .data    (cur_word),
      .weights (WEIGHTS),
      .dot     (cur_dot)
   );

   // Input memory holds data only; it is not cleared by reset.
   always_ff @(posedge clk) begin
      if (!rst_b && write_input) begin
         in_mem[wr_ptr] <= input_sram_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_b) begin
         state   <= ST_IDLE;
         idx     <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         ram_out <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            out_mem[k] <= '0;
         end
      end else begin
         if (write_input) begin
            wr_ptr <= next_ptr(wr_ptr);
         end
         if (read_output) begin
            ram_out <= out_mem[rd_ptr];
            rd_ptr  <= next_ptr(rd_ptr);
         end
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state <= ST_COMPUTE;
                  idx   <= '0;
               end
            end
            ST_COMPUTE: begin
               out_mem[idx] <= {cur_word, {PAD_W{1'b0}}, cur_dot};
               if (idx == ADDR_W'(DEPTH - 1)) begin
                  state <= ST_DONE;
                  idx   <= '0;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
               idx   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_texas_top.sv
// tb_texas_top: directed self-checking bench for texas_top (default weights)
// plus a second instance with all-ones weights for the maximum-sum case.
module tb_texas_top;
   import texas_pkg::*;

   logic        clk = 1'b0;
   logic        rst_b = 1'b0;
   logic [31:0] input_sram_in = '0;
   logic        write_input = 1'b0;
   logic        start = 1'b0;
   logic        read_output = 1'b0;
   logic [63:0] ram_out;
   logic [63:0] ram_out_max;

   int checks = 0;
   int errors = 0;

   logic [31:0] vec_in  [8] = '{32'h00000000, 32'h01000000, 32'h01020000, 32'h01020300,
                                32'h01020304, 32'h00020304, 32'h00000304, 32'h00000004};
   logic [31:0] vec_dot [8] = '{32'd0, 32'd1, 32'd5, 32'd14, 32'd30, 32'd29, 32'd25, 32'd16};

   always #5 clk = ~clk;

   texas_top #(.DEPTH(8), .WEIGHTS(32'h01020304)) dut (
      .clk           (clk),
      .rst_b         (rst_b),
      .input_sram_in (input_sram_in),
      .write_input   (write_input),
      .start         (start),
      .read_output   (read_output),
      .ram_out       (ram_out)
   );

   texas_top #(.DEPTH(8), .WEIGHTS(32'hFFFFFFFF)) dut_max (
      .clk           (clk),
      .rst_b         (rst_b),
      .input_sram_in (input_sram_in),
      .write_input   (write_input),
      .start         (start),
      .read_output   (read_output),
      .ram_out       (ram_out_max)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_b = 1'b1;
      step();
      rst_b = 1'b0;
   endtask

   task automatic write_word(input logic [31:0] w);
      input_sram_in = w;
      write_input   = 1'b1;
      step();
      write_input   = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (ram_out !== 64'h0) begin
         errors++;
         $display("FAIL reset_ram_out got %h want %h", ram_out, 64'h0);
      end
      checks++;
      if (dut.state !== ST_IDLE) begin
         errors++;
         $display("FAIL reset_state got %0d want %0d", dut.state, ST_IDLE);
      end
   endtask

   task automatic test_write_compute();
      logic [63:0] exp;
      do_reset();
      for (int i = 0; i < 8; i++) write_word(vec_in[i]);
      pulse_start();
      checks++;
      if (dut.state !== ST_COMPUTE) begin
         errors++;
         $display("FAIL wc_state_compute got %0d want %0d", dut.state, ST_COMPUTE);
      end
      repeat (8) step();
      checks++;
      if (dut.state !== ST_DONE) begin
         errors++;
         $display("FAIL wc_state_done got %0d want %0d", dut.state, ST_DONE);
      end
      read_output = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         exp = {vec_in[i], vec_dot[i]};
         checks++;
         if (ram_out !== exp) begin
            errors++;
            $display("FAIL wc_read%0d got %h want %h", i, ram_out, exp);
         end
      end
      read_output = 1'b0;
      step();
      exp = {vec_in[7], vec_dot[7]};
      checks++;
      if (ram_out !== exp) begin
         errors++;
         $display("FAIL wc_hold got %h want %h", ram_out, exp);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      for (int i = 0; i < 8; i++) write_word(32'h00000001);
      write_word(32'hFFFFFFFF);
      pulse_start();
      repeat (8) step();
      read_output = 1'b1;
      step();
      checks++;
      if (ram_out !== {32'hFFFFFFFF, 32'h000009F6}) begin
         errors++;
         $display("FAIL wrap_entry0 got %h want %h", ram_out, {32'hFFFFFFFF, 32'h000009F6});
      end
      step();
      checks++;
      if (ram_out !== {32'h00000001, 32'h00000004}) begin
         errors++;
         $display("FAIL wrap_entry1 got %h want %h", ram_out, {32'h00000001, 32'h00000004});
      end
      read_output = 1'b0;
   endtask

   task automatic test_max();
      do_reset();
      write_word(32'hFFFFFFFF);
      pulse_start();
      repeat (8) step();
      read_output = 1'b1;
      step();
      read_output = 1'b0;
      checks++;
      if (ram_out_max !== {32'hFFFFFFFF, 32'h0003F804}) begin
         errors++;
         $display("FAIL max_dot got %h want %h", ram_out_max, {32'hFFFFFFFF, 32'h0003F804});
      end
      checks++;
      if (ram_out !== {32'hFFFFFFFF, 32'h000009F6}) begin
         errors++;
         $display("FAIL max_default_weights got %h want %h", ram_out, {32'hFFFFFFFF, 32'h000009F6});
      end
   endtask

   task automatic test_write_during_compute();
      do_reset();
      for (int i = 0; i < 5; i++) write_word(32'h00000000);
      pulse_start();
      // Entry 5 is written while entry 0 is being processed.
      write_word(32'h01020304);
      repeat (7) step();
      read_output = 1'b1;
      repeat (6) step();
      read_output = 1'b0;
      checks++;
      if (ram_out !== {32'h01020304, 32'd30}) begin
         errors++;
         $display("FAIL wdc_entry5 got %h want %h", ram_out, {32'h01020304, 32'd30});
      end
   endtask

   task automatic test_restart_ignore();
      logic [63:0] exp;
      do_reset();
      for (int i = 0; i < 8; i++) write_word(vec_in[i]);
      start = 1'b1;
      step();
      repeat (7) step();
      checks++;
      if (dut.state !== ST_COMPUTE) begin
         errors++;
         $display("FAIL ri_still_compute got %0d want %0d", dut.state, ST_COMPUTE);
      end
      step();
      start = 1'b0;
      checks++;
      if (dut.state !== ST_DONE) begin
         errors++;
         $display("FAIL ri_done_after_8 got %0d want %0d", dut.state, ST_DONE);
      end
      for (int pass = 0; pass < 2; pass++) begin
         read_output = 1'b1;
         for (int i = 0; i < 8; i++) begin
            step();
            exp = {vec_in[i], vec_dot[i]};
            checks++;
            if (ram_out !== exp) begin
               errors++;
               $display("FAIL ri_pass%0d_read%0d got %h want %h", pass, i, ram_out, exp);
            end
         end
         read_output = 1'b0;
         if (pass == 0) begin
            pulse_start();
            checks++;
            if (dut.state !== ST_COMPUTE) begin
               errors++;
               $display("FAIL ri_restart got %0d want %0d", dut.state, ST_COMPUTE);
            end
            repeat (8) step();
            checks++;
            if (dut.state !== ST_DONE) begin
               errors++;
               $display("FAIL ri_redone got %0d want %0d", dut.state, ST_DONE);
            end
         end
      end
   endtask

   task automatic test_reset_during_compute();
      // out_mem holds the previous results here; a reset mid-pass must clear them.
      pulse_start();
      step();
      step();
      rst_b = 1'b1;
      step();
      rst_b = 1'b0;
      checks++;
      if (dut.state !== ST_IDLE) begin
         errors++;
         $display("FAIL rdc_state got %0d want %0d", dut.state, ST_IDLE);
      end
      checks++;
      if (ram_out !== 64'h0) begin
         errors++;
         $display("FAIL rdc_ram_out got %h want %h", ram_out, 64'h0);
      end
      read_output = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         checks++;
         if (ram_out !== 64'h0) begin
            errors++;
            $display("FAIL rdc_read%0d got %h want %h", i, ram_out, 64'h0);
         end
      end
      read_output = 1'b0;
      checks++;
      if (dut.state !== ST_IDLE) begin
         errors++;
         $display("FAIL rdc_stays_idle got %0d want %0d", dut.state, ST_IDLE);
      end
   endtask

   initial begin
      test_reset();
      test_write_compute();
      test_wrap();
      test_max();
      test_write_during_compute();
      test_restart_ignore();
      test_reset_during_compute();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
